// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encoding and the issue-controller state type.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef logic [2:0] alu_opcode_t;

  localparam alu_opcode_t ALU_OP_ADD  = 3'b000;
  localparam alu_opcode_t ALU_OP_SUB  = 3'b001;
  localparam alu_opcode_t ALU_OP_AND  = 3'b010;
  localparam alu_opcode_t ALU_OP_OR   = 3'b011;
  localparam alu_opcode_t ALU_OP_XOR  = 3'b100;
  localparam alu_opcode_t ALU_OP_SHL  = 3'b101;
  localparam alu_opcode_t ALU_OP_SHR  = 3'b110;
  localparam alu_opcode_t ALU_OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator for the alu block: takes one request, pulses the ALU for a cycle, waits the fixed
// ALU latency, captures the result and holds it on a valid/ready response channel.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH       = ALU_WIDTH,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [2:0]        req_opcode_in,
  input  logic [WIDTH-1:0]  req_a_in,
  input  logic [WIDTH-1:0]  req_b_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [WIDTH-1:0]  rsp_data_out,
  output logic [2:0]        rsp_opcode_out,
  output logic              alu_enable_out,
  output logic [2:0]        alu_opcode_out,
  output logic [WIDTH-1:0]  alu_input1_out,
  output logic [WIDTH-1:0]  alu_input2_out,
  input  logic [WIDTH-1:0]  alu_output_in,
  output logic [15:0]       op_count_out
);

  localparam logic [3:0] WAIT_INIT = 4'(ALU_LATENCY - 1);

  issue_state_t state;
  logic [3:0]   wait_cnt;
  logic [15:0]  op_count;

  assign op_count_out  = op_count;
  // Ready looks at rsp_ready_in so a response handshake and the next accept share one edge.
  assign req_ready_out = (state == IDLE) || ((state == RESP) && rsp_ready_in);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      op_count       <= '0;
      rsp_valid_out  <= 1'b0;
      rsp_data_out   <= '0;
      rsp_opcode_out <= '0;
      alu_enable_out <= 1'b0;
      alu_opcode_out <= '0;
      alu_input1_out <= '0;
      alu_input2_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_in) begin
            alu_opcode_out <= req_opcode_in;
            alu_input1_out <= req_a_in;
            alu_input2_out <= req_b_in;
            alu_enable_out <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          alu_enable_out <= 1'b0;
          wait_cnt       <= WAIT_INIT;
          state          <= WAIT;
        end

        WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_data_out   <= alu_output_in;
            rsp_opcode_out <= alu_opcode_out;
            rsp_valid_out  <= 1'b1;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        RESP: begin
          if (rsp_ready_in) begin
            rsp_valid_out <= 1'b0;
            op_count      <= op_count + 16'd1;
            if (req_valid_in) begin
              alu_opcode_out <= req_opcode_in;
              alu_input1_out <= req_a_in;
              alu_input2_out <= req_b_in;
              alu_enable_out <= 1'b1;
              state          <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a latency-1 ALU model; directed scenarios plus a randomized
// run scored against a queue of expected results.
module tb_alu_issue_ctrl;

  logic       clk, rst;
  logic       req_valid, req_ready;
  logic [2:0] req_opcode;
  logic [7:0] req_a, req_b;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_opcode;
  logic       alu_enable;
  logic [2:0] alu_opcode;
  logic [7:0] alu_in1, alu_in2, alu_out;
  logic [15:0] op_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_count = '0;

  alu_issue_ctrl #(.WIDTH(8), .ALU_LATENCY(1)) dut (
    .clock_in(clk), .reset_in(rst),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_opcode_in(req_opcode), .req_a_in(req_a), .req_b_in(req_b),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready),
    .rsp_data_out(rsp_data), .rsp_opcode_out(rsp_opcode),
    .alu_enable_out(alu_enable), .alu_opcode_out(alu_opcode),
    .alu_input1_out(alu_in1), .alu_input2_out(alu_in2),
    .alu_output_in(alu_out), .op_count_out(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << 1;
      3'd6: return a >> 1;
      default: return ~a;
    endcase
  endfunction

  // ALU model: result valid for exactly one cycle after an enabled edge, garbage otherwise.
  always @(posedge clk) begin
    if (alu_enable) alu_out <= alu_ref(alu_opcode, alu_in1, alu_in2);
    else            alu_out <= 8'($urandom);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic [2:0] o, output bit timeout);
    int n;
    timeout = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) timeout = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!rsp_valid) timeout = 1'b1;
    d = rsp_data;
    o = rsp_opcode;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_data, rsp_opcode, alu_enable, alu_opcode, alu_in1, alu_in2, op_count} !== '0) begin
      bad++;
      $display("FAIL reset_values got v=%b d=%h o=%h en=%b op=%h a=%h b=%h cnt=%h want all zero",
               rsp_valid, rsp_data, rsp_opcode, alu_enable, alu_opcode, alu_in1, alu_in2, op_count);
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    exp_count = '0;
  endtask

  task automatic test_reset_in_wait();
    logic [7:0] d; logic [2:0] o; bit to; bit seen;
    apply_reset();
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 3'd0; req_a = 8'h11; req_b = 8'h22; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({rsp_valid, alu_enable, alu_in1, alu_in2, op_count} !== '0) begin
      bad++;
      $display("FAIL reset_in_wait_async got v=%b en=%b a=%h b=%h cnt=%h want all zero",
               rsp_valid, alu_enable, alu_in1, alu_in2, op_count);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
    total++;
    if (seen || op_count !== 16'd0) begin
      bad++; $display("FAIL reset_in_wait_dropped got rsp_seen=%b cnt=%h want 0/0000", seen, op_count);
    end
    run_op(3'd0, 8'h10, 8'h22, d, o, to);
    exp_count++;
    total++;
    if (to || d !== 8'h32 || op_count !== exp_count) begin
      bad++; $display("FAIL reset_in_wait_next got to=%b d=%h cnt=%h want d=32 cnt=%h", to, d, op_count, exp_count);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 3'd0; req_a = 8'h03; req_b = 8'h05; rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (alu_enable !== 1'b1 || alu_in1 !== 8'h03 || alu_in2 !== 8'h05 || alu_opcode !== 3'd0) begin
      bad++; $display("FAIL single_issue got en=%b a=%h b=%h op=%h want 1/03/05/0", alu_enable, alu_in1, alu_in2, alu_opcode);
    end
    @(negedge clk);
    total++;
    if (alu_enable !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_wait got en=%b v=%b want 0/0", alu_enable, rsp_valid);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h08 || rsp_opcode !== 3'd0) begin
      bad++; $display("FAIL single_resp got v=%b d=%h o=%h want 1/08/0", rsp_valid, rsp_data, rsp_opcode);
    end
    @(negedge clk);
    exp_count++;
    total++;
    if (rsp_valid !== 1'b0 || op_count !== exp_count) begin
      bad++; $display("FAIL single_count got v=%b cnt=%h want 0/%h", rsp_valid, op_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d; logic [2:0] o; bit to;
    run_op(3'd0, 8'hFF, 8'h01, d, o, to);
    exp_count++;
    total++;
    if (to || d !== 8'h00 || o !== 3'd0 || op_count !== exp_count) begin
      bad++; $display("FAIL data_wrap got to=%b d=%h o=%h cnt=%h want d=00 cnt=%h", to, d, o, op_count, exp_count);
    end
  endtask

  task automatic test_count_wrap();
    logic [7:0] d; logic [2:0] o; bit to;
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    exp_count = 16'hFFFF;
    run_op(3'd4, 8'h5A, 8'h0F, d, o, to);
    exp_count++;
    total++;
    if (to || d !== 8'h55 || op_count !== 16'h0000 || op_count !== exp_count) begin
      bad++; $display("FAIL count_wrap got to=%b d=%h cnt=%h want d=55 cnt=0000", to, d, op_count);
    end
  endtask

  task automatic test_backpressure();
    int n; logic [7:0] held; bit unstable;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 3'd1; req_a = 8'h40; req_b = 8'h01; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    held = rsp_data;
    total++;
    if (rsp_valid !== 1'b1 || held !== 8'h3F) begin
      bad++; $display("FAIL bp_first got v=%b d=%h want 1/3F", rsp_valid, held);
    end
    req_valid = 1'b1; req_opcode = 3'd3; req_a = 8'hA0; req_b = 8'h05;
    unstable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_opcode !== 3'd1 ||
          req_ready !== 1'b0 || alu_enable !== 1'b0) unstable = 1'b1;
    end
    total++;
    if (unstable) begin
      bad++; $display("FAIL bp_stall got v=%b d=%h rdy=%b en=%b want 1/%h/0/0", rsp_valid, rsp_data, req_ready, alu_enable, held);
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    exp_count++;
    total++;
    if (rsp_valid !== 1'b0 || alu_enable !== 1'b1 || alu_in1 !== 8'hA0 || op_count !== exp_count) begin
      bad++; $display("FAIL bp_same_cycle got v=%b en=%b a=%h cnt=%h want 0/1/A0/%h", rsp_valid, alu_enable, alu_in1, op_count, exp_count);
    end
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_opcode !== 3'd3) begin
      bad++; $display("FAIL bp_second got v=%b d=%h o=%h want 1/A5/3", rsp_valid, rsp_data, rsp_opcode);
    end
    @(negedge clk);
    exp_count++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [4];
    logic [7:0] bv [4];
    int idx, got, last_cyc, cyc;
    bit order_ok, gap_ok;
    av[0] = 8'd0; bv[0] = 8'd0; av[1] = 8'd0; bv[1] = 8'd1;
    av[2] = 8'd1; bv[2] = 8'd0; av[3] = 8'd1; bv[3] = 8'd1;
    apply_reset();
    idx = 0; got = 0; cyc = 0; last_cyc = -1; order_ok = 1'b1; gap_ok = 1'b1;
    rsp_ready = 1'b1;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        if (rsp_data !== av[got] + bv[got]) order_ok = 1'b0;
        if (last_cyc >= 0 && cyc - last_cyc != 3) gap_ok = 1'b0;
        last_cyc = cyc;
        got++;
      end
      req_valid = (idx < 4); req_opcode = 3'd0;
      req_a = av[idx & 3]; req_b = bv[idx & 3];
      #1;
      if (req_valid && req_ready) idx++;
    end
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (got != 4 || !order_ok) begin bad++; $display("FAIL b2b_results got count=%0d order_ok=%b want 4/1", got, order_ok); end
    total++;
    if (!gap_ok) begin bad++; $display("FAIL b2b_spacing got irregular spacing want one result per 3 cycles"); end
    total++;
    if (op_count !== 16'd4) begin bad++; $display("FAIL b2b_count got=%h want=0004", op_count); end
    exp_count = 16'd4;
  endtask

  task automatic test_random();
    logic [10:0] q [$];
    logic [10:0] e;
    bit stall; logic [7:0] sd; logic [2:0] so;
    int bad_before;
    bad_before = bad;
    stall = 1'b0; sd = '0; so = '0;
    for (int c = 0; c < 460; c++) begin
      @(negedge clk);
      if (stall) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== sd || rsp_opcode !== so) begin
          bad++; $display("FAIL rand_stall got v=%b d=%h o=%h want 1/%h/%h", rsp_valid, rsp_data, rsp_opcode, sd, so);
        end
      end
      if (c < 400) begin
        req_valid = ($urandom % 3) != 0;
        req_opcode = 3'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
        rsp_ready = ($urandom % 4) != 0;
      end else begin
        req_valid = 1'b0; rsp_ready = 1'b1;
      end
      #1;
      if (req_valid && req_ready) q.push_back({req_opcode, alu_ref(req_opcode, req_a, req_b)});
      if (rsp_valid && rsp_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_unexpected got d=%h o=%h want no response", rsp_data, rsp_opcode);
        end else begin
          e = q.pop_front();
          if ({rsp_opcode, rsp_data} !== e) begin
            bad++; $display("FAIL rand_result got o=%h d=%h want o=%h d=%h", rsp_opcode, rsp_data, e[10:8], e[7:0]);
          end
        end
        exp_count++;
      end
      stall = rsp_valid && !rsp_ready;
      sd = rsp_data; so = rsp_opcode;
    end
    @(negedge clk);
    total++;
    if (q.size() != 0 || op_count !== exp_count) begin
      bad++; $display("FAIL rand_drain got pending=%0d cnt=%h want 0/%h", q.size(), op_count, exp_count);
    end
    if (bad != bad_before) $display("random phase reported %0d problems", bad - bad_before);
  endtask

  initial begin
    test_reset();
    test_reset_in_wait();
    test_single();
    test_wrap();
    test_count_wrap();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
